// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver and its consumer (Recep).
// Holds the prefix codes, a few scan codes used by the command interpreter,
// the frame and decoder state types, and the frame parity helper.
package ps2_scancode_rx_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Scan codes consumed by Recep
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_R     = 8'h2D;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef enum logic {
    NORMAL,
    BREAK
  } dec_state_t;

  // Data plus parity must carry an odd number of ones
  function automatic logic odd_ones(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Bus between the PS/2 receiver and its surroundings.
//   PS2C, PS2D : raw PS/2 clock and data lines (asynchronous, receive only)
//   DATO       : last accepted scan code
//   flag       : one-cycle strobe, DATO just updated
//   ERR        : one-cycle strobe, parity/framing/timeout error
// master: the receiver; slave: the keyboard side plus the code consumer.
interface ps2_scancode_rx_if;
  logic       PS2C;
  logic       PS2D;
  logic [7:0] DATO;
  logic       flag;
  logic       ERR;

  modport master (input PS2C, input PS2D, output DATO, output flag, output ERR);
  modport slave  (output PS2C, output PS2D, input DATO, input flag, input ERR);
endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// ps2_line_filter: 2-FF synchroniser followed by a stability counter.
// The output follows the synchronised input only after FILTER_LEN consecutive
// samples that differ from the current output; shorter glitches are dropped.
//   clk   : system clock
//   rst_n : asynchronous reset, active low (output resets to 1, idle line)
//   din   : asynchronous line input
//   dout  : filtered line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        dout <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver.
// Conditions PS2C/PS2D, deserialises 11-bit device-to-host frames, drops
// extended (E0) and, optionally, break (F0 + following code) prefixes and
// presents each make code on DATO with a one-cycle flag strobe.
//   CLK     : system clock
//   RESET_N : asynchronous reset, active low
//   bus     : PS2C/PS2D in, DATO/flag/ERR out
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DROP_BREAK     = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  ps2_scancode_rx_if.master    bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fc;
  logic          fd;
  logic          fc_q;
  logic          fall;
  frame_state_t  state;
  logic [2:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    sr;
  logic          par;
  logic          byte_stb;
  logic          err_stb;
  logic [7:0]    rx_byte;
  dec_state_t    dstate;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (bus.PS2C),
    .dout  (fc)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (bus.PS2D),
    .dout  (fd)
  );

  always_comb begin
    fall = fc_q & ~fc;
  end

  // Frame FSM; byte_stb/err_stb are mutually exclusive registered strobes
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      bcnt     <= '0;
      tcnt     <= '0;
      sr       <= '0;
      par      <= 1'b0;
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      rx_byte  <= '0;
      fc_q     <= 1'b1;
    end else begin
      fc_q     <= fc;
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: begin
            if (!fd) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            sr   <= {fd, sr[7:1]};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= fd;
            state <= STOP;
          end
          STOP: begin
            if (fd && odd_ones({par, sr})) begin
              byte_stb <= 1'b1;
              rx_byte  <= sr;
            end else begin
              err_stb <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state   <= IDLE;
        err_stb <= 1'b1;
        tcnt    <= '0;
      end
    end
  end

  // Prefix decoder and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dstate   <= NORMAL;
      bus.DATO <= '0;
      bus.flag <= 1'b0;
      bus.ERR  <= 1'b0;
    end else begin
      bus.flag <= 1'b0;
      bus.ERR  <= err_stb;
      if (byte_stb) begin
        case (dstate)
          NORMAL: begin
            if (rx_byte == SC_EXT) begin
              dstate <= NORMAL;
            end else if (DROP_BREAK != 0 && rx_byte == SC_BREAK) begin
              dstate <= BREAK;
            end else begin
              bus.DATO <= rx_byte;
              bus.flag <= 1'b1;
            end
          end
          BREAK: begin
            if (rx_byte != SC_EXT) dstate <= NORMAL;
          end
          default: dstate <= NORMAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: hand-written corner sequences,
// a table of frames with expected decoder results, and random frames checked
// against a rule-level model of the prefix decoder.
module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 300;
  localparam int HP = 20;  // PS/2 clock half period in CLK cycles

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    int         eflag;
    int         eerr;
    logic [7:0] edato;
  } tv_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .DROP_BREAK     (1)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int nflag  = 0;
  int nerr   = 0;
  int viol   = 0;
  logic       prev_flag = 1'b0;
  logic [7:0] prev_dato = 8'h00;

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (bus.flag) nflag++;
      if (bus.ERR) nerr++;
      if (bus.flag && bus.ERR) viol++;
      if (bus.flag && prev_flag) viol++;
      if (!bus.flag && bus.DATO !== prev_dato) viol++;
    end
    prev_flag <= bus.flag;
    prev_dato <= bus.DATO;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    cyc(HP / 2);
    bus.PS2D = b;
    cyc(HP / 2);
    bus.PS2C = 1'b0;
    cyc(HP);
    bus.PS2C = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par,
                            input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, code, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    cyc(HP);
    bus.PS2D = 1'b1;
  endtask

  function automatic logic oddp(input logic [7:0] c);
    return ~^c;
  endfunction

  task automatic frame_chk(input string nm, input logic [7:0] code, input logic par,
                           input logic stp, input int eflag, input int eerr,
                           input logic [7:0] edato);
    int f0, e0;
    f0 = nflag;
    e0 = nerr;
    send_frame(code, par, stp, 11);
    cyc(10);
    chk({nm, " flags"}, nflag - f0, eflag);
    chk({nm, " errs"}, nerr - e0, eerr);
    chk({nm, " DATO"}, int'(bus.DATO), int'(edato));
  endtask

  tv_t        tv[16];
  int         f0, e0, lat;
  logic [10:0] fr;
  logic       in_brk;
  logic [7:0] exp_d, code;
  logic       badp, bads;
  int         ef, ee;

  initial begin
    tv[0]  = '{8'h16, 1'b0, 1, 0, 8'h16};
    tv[1]  = '{8'hF0, 1'b0, 0, 0, 8'h16};
    tv[2]  = '{8'h16, 1'b0, 0, 0, 8'h16};
    tv[3]  = '{8'h3E, 1'b0, 1, 0, 8'h3E};
    tv[4]  = '{8'h16, 1'b1, 0, 1, 8'h3E};
    tv[5]  = '{8'h1C, 1'b0, 1, 0, 8'h1C};
    tv[6]  = '{8'hF0, 1'b0, 0, 0, 8'h1C};
    tv[7]  = '{8'hE0, 1'b0, 0, 0, 8'h1C};
    tv[8]  = '{8'hF0, 1'b0, 0, 0, 8'h1C};
    tv[9]  = '{8'h33, 1'b0, 1, 0, 8'h33};
    tv[10] = '{8'hF0, 1'b0, 0, 0, 8'h33};
    tv[11] = '{8'hF0, 1'b1, 0, 1, 8'h33};
    tv[12] = '{8'h2D, 1'b0, 0, 0, 8'h33};
    tv[13] = '{8'h2D, 1'b0, 1, 0, 8'h2D};
    tv[14] = '{8'hE0, 1'b0, 0, 0, 8'h2D};
    tv[15] = '{8'h5A, 1'b0, 1, 0, 8'h5A};

    bus.PS2C = 1'b1;
    bus.PS2D = 1'b1;

    // 1: reset hold with PS2C toggling, then 5A with latency measurement
    cyc(3);
    for (int i = 0; i < 10; i++) begin
      bus.PS2C = ~bus.PS2C;
      cyc(FL + 4);
    end
    @(negedge CLK);
    chk("reset DATO", int'(bus.DATO), 0);
    chk("reset flag", int'(bus.flag), 0);
    chk("reset ERR", int'(bus.ERR), 0);
    bus.PS2C = 1'b1;
    cyc(FL + 4);
    RESET_N = 1'b1;
    cyc(5);
    f0 = nflag;
    fr = {1'b1, 1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(fr[i]);
    cyc(HP / 2);
    bus.PS2D = 1'b1;
    cyc(HP / 2);
    bus.PS2C = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.flag) begin
        lat = n;
        break;
      end
    end
    cyc(HP);
    bus.PS2C = 1'b1;
    cyc(10);
    chk("5A latency", lat, FL + 4);
    chk("5A flags", nflag - f0, 1);
    chk("5A DATO", int'(bus.DATO), 8'h5A);

    // 4: partial frame then silence -> timeout error
    f0 = nflag;
    e0 = nerr;
    send_frame(8'h33, 1'b1, 1'b1, 5);
    cyc(TO + 10 + 20);
    chk("timeout errs", nerr - e0, 1);
    chk("timeout flags", nflag - f0, 0);
    frame_chk("after timeout 33", 8'h33, oddp(8'h33), 1'b1, 1, 0, 8'h33);

    // 5: short PS2C glitch with PS2D low must not start a frame
    f0 = nflag;
    e0 = nerr;
    bus.PS2D = 1'b0;
    cyc(2);
    bus.PS2C = 1'b0;
    cyc(FL - 2);
    bus.PS2C = 1'b1;
    cyc(2);
    bus.PS2D = 1'b1;
    cyc(50);
    chk("glitch flags", nflag - f0, 0);
    chk("glitch errs", nerr - e0, 0);
    frame_chk("glitch E0", 8'hE0, oddp(8'hE0), 1'b1, 0, 0, 8'h33);
    frame_chk("glitch 5A", 8'h5A, oddp(8'h5A), 1'b1, 1, 0, 8'h5A);

    // 6: reset after bit 6 of 2D discards the partial frame
    f0 = nflag;
    e0 = nerr;
    send_frame(8'h2D, 1'b1, 1'b1, 7);
    cyc(5);
    RESET_N = 1'b0;
    cyc(3);
    chk("midreset DATO", int'(bus.DATO), 0);
    RESET_N = 1'b1;
    cyc(50);
    chk("midreset flags", nflag - f0, 0);
    chk("midreset errs", nerr - e0, 0);
    frame_chk("after reset 2D", 8'h2D, oddp(8'h2D), 1'b1, 1, 0, 8'h2D);

    // Table-driven frame sequence
    for (int i = 0; i < 16; i++) begin
      frame_chk($sformatf("tv%0d", i), tv[i].code, oddp(tv[i].code) ^ tv[i].bad_par,
                1'b1, tv[i].eflag, tv[i].eerr, tv[i].edato);
    end

    // Random frames against the decoder rules
    in_brk = 1'b0;
    exp_d  = 8'h5A;
    for (int k = 0; k < 24; k++) begin
      code = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: code = 8'hF0;
        1: code = 8'hE0;
        default: ;
      endcase
      badp = ($urandom_range(0, 7) == 0);
      bads = ($urandom_range(0, 9) == 0);
      ef = 0;
      ee = 0;
      if (badp || bads) ee = 1;
      else if (code == 8'hE0) ;
      else if (in_brk) in_brk = 1'b0;
      else if (code == 8'hF0) in_brk = 1'b1;
      else begin
        ef = 1;
        exp_d = code;
      end
      frame_chk($sformatf("rnd%0d", k), code, oddp(code) ^ badp, ~bads, ef, ee, exp_d);
    end

    chk("strobe invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
